mem_stage_access_unit: RTL and testbench
========================================

// Module: mem_stage_access_unit
// PURPOSE
//  M-stage load/store controller: decodes the access type, checks alignment and the address map, and steers each access to data memory or the device bus.
//  Device accesses use a req/ack handshake with wait states and a timeout, and stall the pipeline until they complete.
//  Reports AdEL/AdES/DBE exceptions to CP0 with EPC and BD, tracking delay slots internally.
// PARAMETERS
//  DM_TOP      32'h0000_3000  first address above data memory; DM range is [0, DM_TOP)
//  DEV_BASE    32'h0000_7F00  first device register address
//  DEV_TOP     32'h0000_7F1C  last valid device word address (inclusive)
//  TIMEOUT     16             cycles without dev_ack before a bus error; must be >= 2
//  TO_W        5              counter width; must satisfy 2^TO_W > TIMEOUT
// PORTS
//  clk         in   1   clock, rising edge
//  reset_n     in   1   asynchronous active-low reset
//  valid_m     in   1   M-stage instruction is valid
//  flush_m     in   1   kill the M-stage instruction (exception or eret)
//  mem_op      in   4   0 NONE, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 SB, 7 SH, 8 SW; other codes = NONE
//  branch_m    in   1   M-stage instruction is a branch or jump
//  addr_m      in   32  effective address
//  wdata_m     in   32  store data, right-aligned
//  pc8_m       in   32  PC+8 of the M-stage instruction
//  dm_rdata    in   32  data memory read word, combinational
//  dm_we       out  1   data memory write enable
//  dm_be       out  4   data memory byte enables
//  dm_wdata    out  32  store data replicated into every lane
//  dev_req     out  1   device request
//  dev_we      out  1   device write
//  dev_addr    out  32  device word address
//  dev_wdata   out  32  device write data
//  dev_ack     in   1   device completion, single-cycle pulse
//  dev_rdata   in   32  device read data, valid when dev_ack=1
//  rdata_m     out  32  load result, extended
//  stall_m     out  1   hold the F, D, E and M stages
//  exc_valid   out  1   exception raised this cycle
//  exc_code    out  5   4 AdEL, 5 AdES, 7 DBE
//  epc         out  32  exception PC
//  exc_bd      out  1   excepting instruction sits in a delay slot
// BEHAVIOUR
//  Reset: FSM=IDLE, prev_branch=0; all registered outputs and dev_* outputs are 0.
//  act = valid_m & ~flush_m & mem_op != NONE. Range checks use unsigned addr_m.
//  Address exception, combinational, only when act:
//   - misaligned: LW/SW with addr[1:0]!=0; LH/LHU/SH with addr[0]!=0
//   - unmapped: addr outside [0,DM_TOP) and outside [DEV_BASE,DEV_TOP]
//   - sub-word device access: a byte or half access inside the device range
//   Loads raise code 4, stores raise code 5. The access is suppressed: dm_we=0 and no dev_req.
//  DM path (IDLE, no exception): zero-latency access.
//   - dm_be: SW 1111; SH 0011<<addr[1:0]; SB 0001<<addr[1:0]
//   - loads select the byte/half lane of dm_rdata; LB/LH sign-extend, LBU/LHU zero-extend
//  Device FSM: IDLE -> REQ -> DONE -> IDLE.
//   - IDLE: an act word access in the device range, with no exception, moves to REQ.
//     addr, we and wdata are latched into dev_*. stall_m=1 on this cycle.
//   - REQ: dev_req=1 with dev_* held stable; stall_m=1; the counter increments each cycle.
//     dev_ack=1 captures dev_rdata and moves to DONE.
//     The counter reaching TIMEOUT moves to DONE with an error flag set.
//   - DONE: dev_req=0, stall_m=0, rdata_m=captured data. The instruction retires this cycle.
//     If the error flag is set, exc_valid=1 with code 7. The FSM returns to IDLE.
//   - flush_m is ignored in REQ and DONE; a device access in flight is never abandoned.
//   - dev_ack outside REQ is ignored. dev_ack in the same cycle as the timeout: the ack wins.
//  Delay slot tracking: prev_branch <= branch_m on every cycle with valid_m & ~stall_m.
//   exc_bd=prev_branch; epc = prev_branch ? pc8_m-12 : pc8_m-8.
//  Asynchronous reset mid-REQ: the FSM returns to IDLE immediately and dev_req drops to 0.
// TESTING
//  1. SH at 0x1002, wdata 0xBEEF -> dm_we=1, dm_be=1100, dm_wdata=0xBEEFBEEF, no exception.
//  2. LW at 0x0006 -> exc_valid=1, code 4, dm_we=0; if the previous instruction was a branch,
//     pc8=0x3010 -> epc=0x3004 and exc_bd=1.
//  3. LW at 0x7F04 with dev_ack after 3 REQ cycles, dev_rdata=0x1234 -> stall_m high
//     for 4 cycles, then rdata_m=0x1234 in DONE.
//  4. SW at 0x7F08 and no ack -> exc code 7 in DONE after TIMEOUT REQ cycles.
//  5. SB at 0x7F00 -> code 5, no dev_req. LB at 0x5000 -> code 4. LB at 0x2FFF, byte 0x80
//     -> rdata_m=0xFFFFFF80.
//  6. reset_n asserted mid-REQ -> dev_req=0 immediately; the next access after reset proceeds normally.

Source files
------------

// File: rtl/mem_stage_access_unit.sv
// M-stage load/store unit: decode, alignment/map checks, DM access,
// device bus handshake with timeout, and address/bus exceptions.
module mem_stage_access_unit #(
  parameter logic [31:0] DM_TOP   = 32'h0000_3000,
  parameter logic [31:0] DEV_BASE = 32'h0000_7F00,
  parameter logic [31:0] DEV_TOP  = 32'h0000_7F1C,
  parameter int          TIMEOUT  = 16,
  parameter int          TO_W     = 5
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        valid_m,
  input  logic        flush_m,
  input  logic [3:0]  mem_op,
  input  logic        branch_m,
  input  logic [31:0] addr_m,
  input  logic [31:0] wdata_m,
  input  logic [31:0] pc8_m,
  input  logic [31:0] dm_rdata,
  output logic        dm_we,
  output logic [3:0]  dm_be,
  output logic [31:0] dm_wdata,
  output logic        dev_req,
  output logic        dev_we,
  output logic [31:0] dev_addr,
  output logic [31:0] dev_wdata,
  input  logic        dev_ack,
  input  logic [31:0] dev_rdata,
  output logic [31:0] rdata_m,
  output logic        stall_m,
  output logic        exc_valid,
  output logic [4:0]  exc_code,
  output logic [31:0] epc,
  output logic        exc_bd
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [TO_W-1:0] TO_LIM = TO_W'(TIMEOUT);

  logic [1:0]      state;
  logic [TO_W-1:0] cnt;
  logic [TO_W-1:0] cnt_nxt;
  logic            err;
  logic [31:0]     cap;
  logic            prev_branch;

  logic is_ld, is_st, sz_b, sz_h, sz_w, sx;
  logic act, idle, done;
  logic in_dm, in_dev, mis, adr_bad, adr_exc;
  logic dm_go, dev_go;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] ld_ext;

  // Access type decode
  always_comb begin
    is_ld = 1'b0;
    is_st = 1'b0;
    sz_b  = 1'b0;
    sz_h  = 1'b0;
    sz_w  = 1'b0;
    sx    = 1'b0;
    case (mem_op)
      4'd1: begin is_ld = 1'b1; sz_b = 1'b1; sx = 1'b1; end
      4'd2: begin is_ld = 1'b1; sz_b = 1'b1; end
      4'd3: begin is_ld = 1'b1; sz_h = 1'b1; sx = 1'b1; end
      4'd4: begin is_ld = 1'b1; sz_h = 1'b1; end
      4'd5: begin is_ld = 1'b1; sz_w = 1'b1; end
      4'd6: begin is_st = 1'b1; sz_b = 1'b1; end
      4'd7: begin is_st = 1'b1; sz_h = 1'b1; end
      4'd8: begin is_st = 1'b1; sz_w = 1'b1; end
      default: ;
    endcase
  end

  assign idle = (state == S_IDLE);
  assign done = (state == S_DONE);
  assign act  = valid_m & ~flush_m & (is_ld | is_st);

  assign in_dm   = addr_m < DM_TOP;
  assign in_dev  = (addr_m >= DEV_BASE) & (addr_m <= DEV_TOP);
  assign mis     = (sz_w & (|addr_m[1:0])) | (sz_h & addr_m[0]);
  assign adr_bad = mis | (~in_dm & ~in_dev) | (in_dev & ~sz_w);
  assign adr_exc = act & idle & adr_bad;

  assign dm_go  = act & idle & ~adr_bad & in_dm;
  assign dev_go = act & idle & ~adr_bad & in_dev;

  // Data memory write steering
  always_comb begin
    dm_we    = dm_go & is_st;
    dm_be    = 4'b0000;
    dm_wdata = wdata_m;
    unique case (1'b1)
      sz_b: dm_wdata = {4{wdata_m[7:0]}};
      sz_h: dm_wdata = {2{wdata_m[15:0]}};
      default: ;
    endcase
    if (dm_we) begin
      unique case (1'b1)
        sz_w: dm_be = 4'b1111;
        sz_h: dm_be = 4'b0011 << addr_m[1:0];
        default: dm_be = 4'b0001 << addr_m[1:0];
      endcase
    end
  end

  // Load lane select and extension
  always_comb begin
    lane_h = addr_m[1] ? dm_rdata[31:16] : dm_rdata[15:0];
    case (addr_m[1:0])
      2'd0: lane_b = dm_rdata[7:0];
      2'd1: lane_b = dm_rdata[15:8];
      2'd2: lane_b = dm_rdata[23:16];
      default: lane_b = dm_rdata[31:24];
    endcase
    unique case (1'b1)
      sz_b: ld_ext = {{24{sx & lane_b[7]}}, lane_b};
      sz_h: ld_ext = {{16{sx & lane_h[15]}}, lane_h};
      default: ld_ext = dm_rdata;
    endcase
  end

  assign rdata_m = done ? cap : ld_ext;
  assign dev_req = (state == S_REQ);
  assign stall_m = dev_go | dev_req;
  assign cnt_nxt = cnt + 1'b1;

  assign exc_valid = adr_exc | (done & err);
  assign exc_code  = (done & err) ? 5'd7 :
                     adr_exc ? (is_st ? 5'd5 : 5'd4) : 5'd0;
  assign exc_bd    = prev_branch;
  assign epc       = pc8_m - (prev_branch ? 32'd12 : 32'd8);

  // Device transaction FSM; an access once launched always completes
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      err       <= 1'b0;
      cap       <= 32'd0;
      dev_we    <= 1'b0;
      dev_addr  <= 32'd0;
      dev_wdata <= 32'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (dev_go) begin
            state     <= S_REQ;
            cnt       <= '0;
            err       <= 1'b0;
            dev_we    <= is_st;
            dev_addr  <= {addr_m[31:2], 2'b00};
            dev_wdata <= wdata_m;
          end
        end
        S_REQ: begin
          if (dev_ack) begin
            cap   <= dev_rdata;
            state <= S_DONE;
          end else if (cnt_nxt == TO_LIM) begin
            err   <= 1'b1;
            state <= S_DONE;
          end else begin
            cnt <= cnt_nxt;
          end
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Remember whether the last retiring slot was a branch
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_branch <= 1'b0;
    end else if (valid_m & ~stall_m) begin
      prev_branch <= branch_m;
    end
  end

endmodule

// File: tb/tb_mem_stage_access_unit.sv
// Bench for mem_stage_access_unit: directed cases then random
// accesses checked against an arithmetic reference model.
module tb_mem_stage_access_unit;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        valid_m, flush_m, branch_m;
  logic [3:0]  mem_op;
  logic [31:0] addr_m, wdata_m, pc8_m, dm_rdata;
  logic        dm_we;
  logic [3:0]  dm_be;
  logic [31:0] dm_wdata;
  logic        dev_req, dev_we;
  logic [31:0] dev_addr, dev_wdata;
  logic        dev_ack;
  logic [31:0] dev_rdata;
  logic [31:0] rdata_m;
  logic        stall_m, exc_valid, exc_bd;
  logic [4:0]  exc_code;
  logic [31:0] epc;

  int tests = 0;
  int fails = 0;
  bit prev = 1'b0;

  typedef struct {
    bit          ld;
    bit          st;
    bit          bad;
    bit          dm;
    bit          dev;
    logic [4:0]  code;
    logic [3:0]  be;
    logic [31:0] wd;
    logic [31:0] rv;
  } exp_t;

  mem_stage_access_unit dut (
    .clk(clk), .reset_n(reset_n),
    .valid_m(valid_m), .flush_m(flush_m),
    .mem_op(mem_op), .branch_m(branch_m),
    .addr_m(addr_m), .wdata_m(wdata_m),
    .pc8_m(pc8_m), .dm_rdata(dm_rdata),
    .dm_we(dm_we), .dm_be(dm_be), .dm_wdata(dm_wdata),
    .dev_req(dev_req), .dev_we(dev_we),
    .dev_addr(dev_addr), .dev_wdata(dev_wdata),
    .dev_ack(dev_ack), .dev_rdata(dev_rdata),
    .rdata_m(rdata_m), .stall_m(stall_m),
    .exc_valid(exc_valid), .exc_code(exc_code),
    .epc(epc), .exc_bd(exc_bd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [3:0] op,
                                 input logic [31:0] a,
                                 input logic [31:0] w,
                                 input logic [31:0] rd);
    exp_t e;
    int sz, off;
    bit in_dm, in_dev;
    longint mask, v;
    e = '{default: 0};
    sz = (op == 1 || op == 2 || op == 6) ? 1 :
         (op == 3 || op == 4 || op == 7) ? 2 :
         (op == 5 || op == 8) ? 4 : 0;
    e.ld = (op >= 1 && op <= 5);
    e.st = (op >= 6 && op <= 8);
    if (sz == 0) return e;
    off = int'(a % 4);
    in_dm = a < 32'h3000;
    in_dev = a >= 32'h7F00 && a <= 32'h7F1C;
    e.bad = (a % sz != 0) || !(in_dm || in_dev) || (in_dev && sz < 4);
    e.code = e.st ? 5'd5 : 5'd4;
    e.dm = !e.bad && in_dm;
    e.dev = !e.bad && in_dev;
    e.be = 4'(((1 << sz) - 1) << off);
    mask = (64'd1 << (8 * sz)) - 1;
    if (sz == 4) e.wd = w;
    else e.wd = 32'((longint'(w) & mask) *
                    (sz == 1 ? 64'h01010101 : 64'h00010001));
    v = (longint'(rd) >> (8 * off)) & mask;
    if ((op == 1 || op == 3) && ((v >> (8 * sz - 1)) & 1) != 0)
      v = v | ~mask;
    e.rv = 32'(v);
    return e;
  endfunction

  // One instruction in M; lat = REQ cycle carrying the ack, 0 = never
  task automatic access(input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] w, input bit br,
                        input logic [31:0] pc8, input logic [31:0] rd,
                        input int lat, input bit vld, input bit fl);
    exp_t e;
    bit act, acked;
    int nst;
    logic [31:0] dv;
    @(posedge clk); #1;
    valid_m = vld; flush_m = fl; mem_op = op; branch_m = br;
    addr_m = a; wdata_m = w; pc8_m = pc8; dm_rdata = rd;
    dev_ack = 1'($urandom % 2); dev_rdata = $urandom;
    e = model(op, a, w, rd);
    act = vld && !fl && (e.ld || e.st);
    @(negedge clk);
    chk("epc", epc, pc8 - (prev ? 32'd12 : 32'd8));
    chk("exc_bd", exc_bd, prev);
    if (!act) begin
      chk("idle_exc", exc_valid, 0);
      chk("idle_we", dm_we, 0);
      chk("idle_stall", stall_m, 0);
      chk("idle_req", dev_req, 0);
    end else if (e.bad) begin
      chk("adr_exc", exc_valid, 1);
      chk("adr_code", exc_code, e.code);
      chk("adr_we", dm_we, 0);
      chk("adr_stall", stall_m, 0);
      chk("adr_req", dev_req, 0);
    end else if (e.dm) begin
      chk("dm_exc", exc_valid, 0);
      chk("dm_stall", stall_m, 0);
      chk("dm_we", dm_we, e.st);
      if (e.st) begin
        chk("dm_be", dm_be, e.be);
        chk("dm_wdata", dm_wdata, e.wd);
      end else begin
        chk("dm_rdata", rdata_m, e.rv);
      end
    end else begin
      chk("dv_start_exc", exc_valid, 0);
      chk("dv_start_we", dm_we, 0);
      chk("dv_start_req", dev_req, 0);
      nst = stall_m ? 1 : 0;
      acked = 1'b0;
      dv = $urandom;
      for (int i = 1; i <= TO; i++) begin
        @(posedge clk); #1;
        dev_ack = (i == lat);
        dev_rdata = dv;
        @(negedge clk);
        chk("dv_req", dev_req, 1);
        chk("dv_addr", dev_addr, a);
        chk("dv_we", dev_we, e.st);
        chk("dv_wdata", dev_wdata, w);
        if (stall_m) nst++;
        if (i == lat) begin
          acked = 1'b1;
          break;
        end
      end
      @(posedge clk); #1;
      dev_ack = 1'($urandom % 2);
      dev_rdata = ~dv;
      @(negedge clk);
      chk("dv_stall_cycles", nst, acked ? lat + 1 : TO + 1);
      chk("dv_done_stall", stall_m, 0);
      chk("dv_done_req", dev_req, 0);
      chk("dv_done_exc", exc_valid, !acked);
      if (!acked) chk("dv_done_code", exc_code, 7);
      if (acked && e.ld) chk("dv_done_rdata", rdata_m, dv);
      chk("dv_done_epc", epc, pc8 - (prev ? 32'd12 : 32'd8));
    end
    if (vld) prev = br;
  endtask

  initial begin
    logic [31:0] a;
    logic [3:0] op;
    reset_n = 1'b0;
    valid_m = 0; flush_m = 0; mem_op = 0; branch_m = 0;
    addr_m = 0; wdata_m = 0; pc8_m = 32'h8; dm_rdata = 0;
    dev_ack = 0; dev_rdata = 0;
    #3;
    chk("rst_req", dev_req, 0);
    chk("rst_addr", dev_addr, 0);
    chk("rst_we", dev_we, 0);
    chk("rst_wdata", dev_wdata, 0);
    chk("rst_stall", stall_m, 0);
    chk("rst_exc", exc_valid, 0);
    chk("rst_bd", exc_bd, 0);
    @(negedge clk);
    reset_n = 1'b1;

    access(4'd7, 32'h1002, 32'hBEEF, 0, 32'h100, 0, 0, 1, 0);
    access(4'd0, 32'h0, 32'h0, 1, 32'h2FF8, 0, 0, 1, 0);
    access(4'd5, 32'h6, 32'h0, 0, 32'h3010, 0, 0, 1, 0);
    access(4'd5, 32'h7F04, 32'h0, 0, 32'h400, 0, 3, 1, 0);
    access(4'd8, 32'h7F08, 32'hCAFE, 0, 32'h404, 0, 0, 1, 0);
    access(4'd5, 32'h7F1C, 32'h0, 0, 32'h408, 0, TO, 1, 0);
    access(4'd6, 32'h7F00, 32'h55, 0, 32'h40C, 0, 0, 1, 0);
    access(4'd1, 32'h5000, 32'h0, 0, 32'h410, 0, 0, 1, 0);
    access(4'd1, 32'h2FFF, 32'h0, 0, 32'h414, 32'h80123456, 0, 1, 0);
    access(4'd5, 32'h3000, 32'h0, 0, 32'h418, 0, 0, 1, 0);
    access(4'd5, 32'h7F20, 32'h0, 0, 32'h41C, 0, 0, 1, 0);
    access(4'd5, 32'h7F04, 32'h0, 0, 32'h420, 0, 1, 1, 1);

    // reset while a device store is waiting for its ack
    @(posedge clk); #1;
    valid_m = 1; flush_m = 0; mem_op = 4'd8; branch_m = 0;
    addr_m = 32'h7F10; wdata_m = 32'h1111; dev_ack = 0;
    @(negedge clk);
    chk("r6_stall", stall_m, 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("r6_req", dev_req, 1);
    #2;
    valid_m = 0;
    reset_n = 1'b0;
    #1;
    chk("r6_req_drop", dev_req, 0);
    chk("r6_addr_clr", dev_addr, 0);
    chk("r6_stall_clr", stall_m, 0);
    @(negedge clk);
    reset_n = 1'b1;
    prev = 1'b0;
    access(4'd5, 32'h7F14, 32'h0, 0, 32'h500, 0, 2, 1, 0);

    for (int n = 0; n < 250; n++) begin
      op = 4'($urandom % 16);
      case ($urandom % 5)
        0: a = $urandom % 32'h3000;
        1: a = 32'h7F00 + ($urandom % 32);
        2: a = 32'h2FF8 + ($urandom % 16);
        3: a = 32'h7EF8 + ($urandom % 16);
        default: a = $urandom;
      endcase
      access(op, a, $urandom, 1'($urandom % 2), $urandom,
             $urandom, $urandom_range(0, TO),
             ($urandom % 10) != 0, ($urandom % 10) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
